// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: load/enable/status bundle for the BCD down-counter
interface bcd_down_counter_if #(parameter int DIGITS = 2);
  logic                pe_n;
  logic [4*DIGITS-1:0] p;
  logic                cep;
  logic                cet;
  logic [4*DIGITS-1:0] q;
  logic                tc;
  logic                zero;
  logic                done;
  modport master (output pe_n, p, cep, cet, input q, tc, zero, done);
  modport slave (input pe_n, p, cep, cet, output q, tc, zero, done);
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD down-counter with load, enables, tc and done pulse.
// Optional macro AUTO_RELOAD_EN: a count step at zero reloads p instead of wrapping to all-9s.
module bcd_down_counter #(parameter int DIGITS = 2) (
  input logic cp,
  input logic mr_n,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] q, dec, nxt;
  logic         b, cnt, zero;
  assign zero = (q == '0);
  assign cnt = bus.cep & bus.cet;
`ifdef AUTO_RELOAD_EN
  assign nxt = zero ? bus.p : dec;
`else
  assign nxt = dec;
`endif
  assign bus.q = q;
  assign bus.zero = zero;
  assign bus.tc = bus.cet & zero;
  // Borrow ripple: a digit steps down only when every lower digit was 0; invalid digits step in binary and stop the borrow.
  always_comb begin
    b = 1'b1;
    dec = q;
    for (int i = 0; i < DIGITS; i++) begin
      dec[4*i+:4] = b ? ((q[4*i+:4] == 4'd0) ? 4'd9 : q[4*i+:4] - 4'd1) : q[4*i+:4];
      b = b & (q[4*i+:4] == 4'd0);
    end
  end
  // Counter state and the one-cycle done pulse on a 1 -> 0 count step.
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      q <= '0;
      bus.done <= 1'b0;
    end else begin
      q <= !bus.pe_n ? bus.p : cnt ? nxt : q;
      bus.done <= bus.pe_n & cnt & (q == W'(1));
    end
  end
endmodule
